dmem_port_arbiter: RTL and testbench
====================================

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of all requester and memory address buses.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width of all write/read buses.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4 (range 1-7), meaning consecutive core grants tolerated while dbg is pending.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports named as below.
REQ-005 SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-006 SHALL have port reset, input, 1, meaning the asynchronous active-high reset.
REQ-007 SHALL have ports core_req/core_we, input, 1 each, meaning core request and write strobe.
REQ-008 SHALL have ports core_addr (ADDR_W) and core_wdata (DATA_W), input, meaning the core request payload.
REQ-009 SHALL have ports core_rdata (DATA_W) and core_ack (1), output, meaning core read data and completion pulse.
REQ-010 SHALL have ports dbg_req, dbg_we, dbg_addr and dbg_wdata, input, with the same widths as the core, meaning debug/LCD readback requester.
REQ-011 SHALL have ports dbg_rdata (DATA_W) and dbg_ack (1), output, meaning debug read data and completion pulse.
REQ-012 SHALL have ports mem_we (1), mem_addr (ADDR_W) and mem_wdata (DATA_W), output, meaning the single synchronous-RAM port.
REQ-013 SHALL have port mem_rdata, input, DATA_W, meaning RAM read data, valid one cycle after the address cycle.
REQ-014 SHALL have port busy, output, 1, meaning that the FSM is not in IDLE.

Function
REQ-015 SHALL implement an FSM with states IDLE, ACC and CAP; each transaction follows IDLE->ACC->CAP->IDLE.
REQ-016 SHALL sample requests only in IDLE, ignoring any requester whose ack is high in that cycle.
REQ-017 SHALL grant the core over dbg by fixed priority, except as stated in REQ-018.
REQ-018 SHALL grant dbg when both request and the starve counter equals STARVE_LIMIT.
REQ-019 SHALL increment the 3-bit starve counter on each core grant made while dbg_req is high, and clear it on a dbg grant or on any arbitration with dbg_req low.
REQ-020 SHALL latch the winner's we, addr and wdata at the grant edge and drive them on mem_* for exactly the ACC cycle.
REQ-021 SHALL hold mem_we at 0 outside ACC, and hold mem_addr/mem_wdata at their last values.
REQ-022 SHALL load the winner's rdata register from mem_rdata at the end of CAP and pulse the winner's ack for one cycle, in the following IDLE cycle.
REQ-023 SHALL complete writes the same way, with rdata reflecting the RAM read-during-write output.
REQ-024 SHALL give a latency of 3 cycles: req seen in IDLE at cycle 0, ACC at cycle 1, CAP at cycle 2, ack at cycle 3.
REQ-025 SHALL hold each rdata register until that requester's next completion.
REQ-026 SHALL require requesters to hold req and payload stable until ack; a req dropped before ack does not abort the transaction.
REQ-027 SHALL never assert core_ack and dbg_ack in the same cycle.

Reset
REQ-028 SHALL, on reset assertion at any time including mid-transaction, immediately force state IDLE, mem_we=0, acks=0, busy=0, starve counter=0, rdata=0, mem_addr=0 and mem_wdata=0.
REQ-029 SHALL perform no memory write and generate no ack for a transaction interrupted by reset.

Configuration
REQ-030 SHALL, with DMEM_ARB_DBG_WRITE_EN defined, execute dbg_we=1 requests as RAM writes.
REQ-031 SHALL, without DMEM_ARB_DBG_WRITE_EN, treat dbg_we as 0: the access becomes a read, mem_we stays 0 and dbg_ack still pulses.

Structure
REQ-032 SHALL place the FSM state enum, owner encoding (NONE/CORE/DBG) and STARVE_LIMIT default in shared package dmem_arb_pkg.
REQ-033 SHALL place grant decision and starve counter in one sub-module, dmem_arb_prio.

Verification
REQ-034 SHALL cover: core read, addr 0x10, RAM holds 0x2A -> mem_we=0 at cycle 1, core_rdata=0x2A with core_ack at cycle 3.
REQ-035 SHALL cover: core_req and dbg_req both high at the same time -> core is granted first; dbg_ack follows 3 cycles after core_ack.
REQ-036 SHALL cover: core_req held continuously with dbg_req high and STARVE_LIMIT=4 -> 4 core acks, then 1 dbg ack, then core resumes.
REQ-037 SHALL cover: reset pulse during ACC of a core write to 0x20 -> mem_we drops at once, no core_ack, RAM[0x20] unchanged.
REQ-038 SHALL cover: dbg write of 0x55 to 0x08 -> RAM[0x08]=0x55 with DMEM_ARB_DBG_WRITE_EN defined; RAM unchanged and dbg_ack still pulses without it.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   - FSM state encoding (IDLE / ACC / CAP)
//   - transaction owner encoding (NONE / CORE / DBG)
//   - default starvation limit for the debug requester
package dmem_arb_pkg;

    typedef logic [1:0] arb_state_t;
    typedef logic [1:0] owner_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_ACC  = 2'd1;
    localparam arb_state_t ST_CAP  = 2'd2;

    localparam owner_t OWN_NONE = 2'd0;
    localparam owner_t OWN_CORE = 2'd1;
    localparam owner_t OWN_DBG  = 2'd2;

    localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/dmem_arb_prio.sv
// Grant decision and starvation counter for the data-memory port arbiter.
// Ports:
//   clk, reset   - rising-edge clock, asynchronous active-high reset
//   arb_en       - high while the FSM is in IDLE (grants only happen then)
//   core_req     - core request, already masked by its own ack
//   dbg_req      - debug request, already masked by its own ack
//   grant        - combinational winner for this cycle (OWN_NONE/CORE/DBG)
module dmem_arb_prio
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   arb_en,
    input  logic   core_req,
    input  logic   dbg_req,
    output owner_t grant
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0] starve_cnt;

    // Core wins by fixed priority unless it has already been granted
    // LIMIT times in a row while debug was waiting.
    always_comb begin
        grant = OWN_NONE;
        if (arb_en) begin
            if (dbg_req && (!core_req || starve_cnt == LIMIT)) begin
                grant = OWN_DBG;
            end else if (core_req) begin
                grant = OWN_CORE;
            end
        end
    end

    // Counter only moves when a grant is actually made; an IDLE cycle
    // with nobody eligible leaves it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 3'd0;
        end else if (grant == OWN_DBG) begin
            starve_cnt <= 3'd0;
        end else if (grant == OWN_CORE) begin
            starve_cnt <= dbg_req ? starve_cnt + 3'd1 : 3'd0;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter in front of a single synchronous-RAM port.
// Each transaction runs IDLE -> ACC -> CAP -> IDLE; the ack for the
// winner pulses in the IDLE cycle after CAP (3 cycles after the request
// was sampled).
// Handshake: a requester raises req with a stable payload and holds both
// until its ack pulse; req is only sampled in IDLE, a requester whose ack
// is high that cycle is ignored, and dropping req after the grant does
// not cancel the access.
// Ports:
//   clk, reset                           - clock, async active-high reset
//   core_req/we/addr/wdata, core_rdata/ack - core requester
//   dbg_req/we/addr/wdata, dbg_rdata/ack   - debug/LCD readback requester
//   mem_we/addr/wdata, mem_rdata         - RAM port (rdata one cycle late)
//   busy                                 - FSM not in IDLE
//   fsm_state                            - current FSM state (debug)
// Build option: DMEM_ARB_DBG_WRITE_EN lets dbg_we=1 perform RAM writes;
// without it debug accesses are always reads.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output arb_state_t        fsm_state
);

    arb_state_t state;
    owner_t     owner;
    owner_t     grant;
    logic       dbg_we_eff;

`ifdef DMEM_ARB_DBG_WRITE_EN
    assign dbg_we_eff = dbg_we;
`else
    // Debug writes are demoted to reads in this build.
    logic dbg_we_unused;
    assign dbg_we_unused = dbg_we;
    assign dbg_we_eff    = 1'b0;
`endif

    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

    dmem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk      (clk),
        .reset    (reset),
        .arb_en   (state == ST_IDLE),
        .core_req (core_req & ~core_ack),
        .dbg_req  (dbg_req & ~dbg_ack),
        .grant    (grant)
    );

    // mem_we is a one-cycle pulse aligned to ACC; mem_addr/mem_wdata are
    // loaded at the grant edge and simply hold afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= OWN_NONE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rdata <= '0;
            dbg_rdata  <= '0;
            core_ack   <= 1'b0;
            dbg_ack    <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            core_ack <= 1'b0;
            dbg_ack  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant == OWN_CORE) begin
                        state     <= ST_ACC;
                        owner     <= OWN_CORE;
                        mem_we    <= core_we;
                        mem_addr  <= core_addr;
                        mem_wdata <= core_wdata;
                    end else if (grant == OWN_DBG) begin
                        state     <= ST_ACC;
                        owner     <= OWN_DBG;
                        mem_we    <= dbg_we_eff;
                        mem_addr  <= dbg_addr;
                        mem_wdata <= dbg_wdata;
                    end
                end
                ST_ACC: begin
                    state <= ST_CAP;
                end
                ST_CAP: begin
                    // mem_rdata now carries the RAM output for the ACC cycle.
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                    if (owner == OWN_CORE) begin
                        core_rdata <= mem_rdata;
                        core_ack   <= 1'b1;
                    end else if (owner == OWN_DBG) begin
                        dbg_rdata <= mem_rdata;
                        dbg_ack   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed vector table,
// hand-written multi-cycle sequences and randomized traffic, all checked
// every cycle against a transaction-level reference model.
// Honours DMEM_ARB_DBG_WRITE_EN the same way as the design.
module tb_dmem_port_arbiter;

    localparam int SL = 4;
`ifdef DMEM_ARB_DBG_WRITE_EN
    localparam bit DBG_WE_EN = 1'b1;
`else
    localparam bit DBG_WE_EN = 1'b0;
`endif

    typedef struct {
        bit          who;        // 0 = core, 1 = dbg
        bit          we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] preload;
        logic [31:0] exp_rdata;
        logic [31:0] exp_ram;
        bit          exp_we;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, dbg_req, dbg_we;
    logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
    logic [31:0] core_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        core_ack, dbg_ack, mem_we, busy;
    logic [1:0]  fsm_state;

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_ack   (core_ack),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_rdata  (dbg_rdata),
        .dbg_ack    (dbg_ack),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    // ---------------- synchronous RAM (write-first) ----------------
    logic [31:0] ram [0:255];
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem_we ? mem_wdata : ram[mem_addr[7:0]];
    end

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          n = 0;           // cycle index
    bit          t_act = 0;       // a transaction is in flight
    int          t_g = 0;         // cycle in which it was granted
    bit          t_who, t_we;
    logic [31:0] t_addr, t_wdata, t_res;
    int          starve = 0;
    logic [31:0] e_core_rdata = 0, e_dbg_rdata = 0, e_mem_addr = 0, e_mem_wdata = 0;
    bit          ack_c_now = 0, ack_d_now = 0;
    logic [31:0] ref_mem [0:255];
    bit          c_act = 0, d_act = 0, c_granted = 0, d_granted = 0;

    // Compare DUT outputs of cycle n with the model's view of that cycle.
    task automatic check_outputs();
        bit e_busy, e_we;
        ack_c_now = t_act && (n == t_g + 3) && !t_who;
        ack_d_now = t_act && (n == t_g + 3) && t_who;
        if (t_act && n == t_g + 1) begin
            e_mem_addr  = t_addr;
            e_mem_wdata = t_wdata;
        end
        if (t_act && n == t_g + 2) begin
            if (t_we) ref_mem[t_addr[7:0]] = t_wdata;
            t_res = ref_mem[t_addr[7:0]];
        end
        if (ack_c_now) e_core_rdata = t_res;
        if (ack_d_now) e_dbg_rdata = t_res;
        if (ack_c_now || ack_d_now) t_act = 0;
        e_busy = t_act && (n == t_g + 1 || n == t_g + 2);
        e_we   = t_act && (n == t_g + 1) && t_we;
        chk("core_ack", core_ack, ack_c_now);
        chk("dbg_ack", dbg_ack, ack_d_now);
        chk("ack_exclusive", core_ack & dbg_ack, 0);
        chk("busy", busy, e_busy);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_mem_addr);
        chk("mem_wdata", mem_wdata, e_mem_wdata);
        chk("core_rdata", core_rdata, e_core_rdata);
        chk("dbg_rdata", dbg_rdata, e_dbg_rdata);
    endtask

    // Decide who (if anyone) the arbiter takes with the current inputs.
    task automatic arbitrate();
        bit c_ok, d_ok, pick_dbg;
        if (!t_act) begin
            c_ok = core_req && !ack_c_now;
            d_ok = dbg_req && !ack_d_now;
            if (c_ok || d_ok) begin
                pick_dbg = d_ok && (!c_ok || starve == SL);
                if (pick_dbg) starve = 0;
                else starve = d_ok ? starve + 1 : 0;
                t_act = 1;
                t_g   = n;
                t_who = pick_dbg;
                if (pick_dbg) begin
                    t_we = dbg_we && DBG_WE_EN;
                    t_addr = dbg_addr;
                    t_wdata = dbg_wdata;
                    d_granted = 1;
                end else begin
                    t_we = core_we;
                    t_addr = core_addr;
                    t_wdata = core_wdata;
                    c_granted = 1;
                end
            end
        end
    endtask

    task automatic advance();
        arbitrate();
        @(posedge clk);
        #1;
        n++;
        check_outputs();
    endtask

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_we = 1; pre_addr = a; pre_data = d;
        ref_mem[a] = d;
        advance();
        pre_we = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_core_ack"}, core_ack, 0);
        chk({tag, "_dbg_ack"}, dbg_ack, 0);
        chk({tag, "_core_rdata"}, core_rdata, 0);
        chk({tag, "_dbg_rdata"}, dbg_rdata, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic clear_model();
        core_req = 0; dbg_req = 0; core_we = 0; dbg_we = 0;
        t_act = 0; starve = 0;
        e_core_rdata = 0; e_dbg_rdata = 0; e_mem_addr = 0; e_mem_wdata = 0;
        ack_c_now = 0; ack_d_now = 0;
        c_act = 0; d_act = 0; c_granted = 0; d_granted = 0;
    endtask

    // Asynchronous reset pulse in the middle of the current cycle.
    task automatic pulse_reset();
        #2 reset = 1;
        #1 check_reset_values("midrst");
        clear_model();
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        advance();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  start;
        int  lat;
        bit  got;
        preload(v.addr, v.preload);
        if (!v.who) begin
            core_req = 1; core_we = v.we; core_addr = {24'h0, v.addr}; core_wdata = v.wdata;
        end else begin
            dbg_req = 1; dbg_we = v.we; dbg_addr = {24'h0, v.addr}; dbg_wdata = v.wdata;
        end
        start = n; lat = -1; got = 0;
        for (int k = 0; k < 8; k++) begin
            advance();
            if (n == start + 1) chk($sformatf("vec%0d_mem_we", idx), mem_we, v.exp_we);
            if (!got && (v.who ? dbg_ack : core_ack)) begin
                got = 1;
                lat = n - start;
                chk($sformatf("vec%0d_rdata", idx), v.who ? dbg_rdata : core_rdata, v.exp_rdata);
                if (v.who) dbg_req = 0; else core_req = 0;
            end
        end
        chk($sformatf("vec%0d_latency", idx), lat, 3);
        chk($sformatf("vec%0d_ram", idx), ram[v.addr], v.exp_ram);
    endtask

    task automatic rand_drive(input bit yield, input bit allow_new);
        if (ack_c_now) begin c_act = 0; c_granted = 0; core_req = 0; end
        if (ack_d_now) begin d_act = 0; d_granted = 0; dbg_req = 0; end
        if (!c_act && allow_new && $urandom_range(0, 2) == 0) begin
            c_act = 1; core_req = 1;
            core_we = 1'($urandom_range(0, 1));
            core_addr = 32'($urandom_range(0, 31));
            core_wdata = $urandom;
        end else if (c_act && c_granted && $urandom_range(0, 7) == 0) begin
            core_req = 0;
        end
        if (!d_act && allow_new && $urandom_range(0, 2) == 0) begin
            d_act = 1;
            dbg_we = 1'($urandom_range(0, 1));
            dbg_addr = 32'($urandom_range(0, 31));
            dbg_wdata = $urandom;
        end
        if (d_act && !d_granted) dbg_req = !(yield && ack_c_now);
        else if (d_act && d_granted && $urandom_range(0, 7) == 0) dbg_req = 0;
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[5];
    int   order[$];
    int   s, ca, da;
    bit   d_pend;

    initial begin
        vecs[0] = '{0, 0, 8'h10, 32'h0,        32'h2A,       32'h2A,       32'h2A,       0};
        vecs[1] = '{0, 1, 8'h11, 32'hDEADBEEF, 32'h1,        32'hDEADBEEF, 32'hDEADBEEF, 1};
        vecs[2] = '{1, 0, 8'h12, 32'h0,        32'h77,       32'h77,       32'h77,       0};
        vecs[3] = '{1, 1, 8'h08, 32'h55,       32'h33,
                    DBG_WE_EN ? 32'h55 : 32'h33, DBG_WE_EN ? 32'h55 : 32'h33, DBG_WE_EN};
        vecs[4] = '{0, 1, 8'h3F, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h0,        1};

        reset = 1; pre_we = 0; pre_addr = 0; pre_data = 0;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        reset = 0;
        advance();

        for (int i = 0; i < 64; i++) preload(8'(i), $urandom);

        // Directed single transactions
        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Simultaneous requests: core first, dbg three cycles later
        core_req = 1; core_we = 0; core_addr = 32'h5;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h6;
        s = n; ca = -1; da = -1;
        for (int k = 0; k < 12; k++) begin
            advance();
            if (core_ack && ca < 0) begin ca = n; core_req = 0; end
            if (dbg_ack && da < 0) begin da = n; dbg_req = 0; end
        end
        chk("both_core_latency", ca - s, 3);
        chk("both_dbg_after_core", da - ca, 3);

        // Starvation: core held, dbg pending (quiet only in core-ack cycles)
        core_req = 1; core_we = 0; core_addr = 32'h7;
        dbg_we = 0; dbg_addr = 32'h9;
        d_pend = 1; dbg_req = 1;
        order.delete();
        for (int k = 0; k < 80; k++) begin
            advance();
            if (core_ack) order.push_back(0);
            if (dbg_ack) begin order.push_back(1); d_pend = 0; end
            dbg_req = d_pend && !ack_c_now;
            if (order.size() >= SL + 2) break;
        end
        core_req = 0; dbg_req = 0;
        chk("starve_ack_count", order.size(), SL + 2);
        for (int i = 0; i < SL + 2; i++)
            chk($sformatf("starve_order%0d", i), (i < order.size()) ? order[i] : 9, (i == SL) ? 1 : 0);

        // Reset during ACC of a core write
        preload(8'h20, 32'h1234);
        core_req = 1; core_we = 1; core_addr = 32'h20; core_wdata = 32'hCAFE;
        advance();
        chk("rst_acc_mem_we", mem_we, 1);
        core_req = 0; core_we = 0;
        pulse_reset();
        repeat (4) advance();
        chk("rst_ram_untouched", ram[8'h20], 32'h1234);

        // Randomized traffic, plain then with dbg yielding in core-ack cycles
        for (int k = 0; k < 800; k++) begin rand_drive(0, 1); advance(); end
        for (int k = 0; k < 800; k++) begin rand_drive(1, 1); advance(); end
        for (int k = 0; k < 20; k++) begin rand_drive(0, 0); advance(); end
        chk("drain_idle", {30'h0, c_act, d_act}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
